// File: rtl/regfile_param_if.sv
// Register-file access bundle: write port, two read ports, issue/scoreboard strobe.
// master = decode/execute side driving addresses, slave = the register file.
interface regfile_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             iss;
    logic [AW-1:0]    iss_addr;
    logic             pend_a;
    logic             pend_b;
    logic [DEPTH-1:0] pend_vec;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, iss, iss_addr,
        input  rdata_a, rdata_b, pend_a, pend_b, pend_vec
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, iss, iss_addr,
        output rdata_a, rdata_b, pend_a, pend_b, pend_vec
    );
endinterface

// File: rtl/regfile_param.sv
// 1W/2R register file with r0 hardwired to zero and per-register pending (scoreboard) bits.
// Latency: writes/issues land on the next clk edge, reads are combinational; RF_BYPASS_EN forwards same-cycle writes.
// Backpressure: none; every write and issue is accepted, clr (async, active-high) clears all state.
module regfile_param #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           clr,
    regfile_param_if.slave rf
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] wsel;
    logic [DEPTH-1:0] isel;

    // One-hot write/issue selects; bit 0 is forced low so r0 never changes.
    always_comb begin
        wsel = '0;
        isel = '0;
        if (rf.we)
            wsel[rf.waddr] = 1'b1;
        if (rf.iss)
            isel[rf.iss_addr] = 1'b1;
        wsel[0] = 1'b0;
        isel[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            regs <= '{default: '0};
        else if (wsel[rf.waddr])
            regs[rf.waddr] <= rf.wdata;
    end

    // Clear on write, then set on issue, so a reissue of the same destination keeps it pending.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            pend <= '0;
        else
            pend <= (pend & ~wsel) | isel;
    end

    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             pd_a;
    logic             pd_b;

    always_comb begin
        rd_a = (rf.raddr_a == '0) ? '0 : regs[rf.raddr_a];
        rd_b = (rf.raddr_b == '0) ? '0 : regs[rf.raddr_b];
        pd_a = pend[rf.raddr_a];
        pd_b = pend[rf.raddr_b];
`ifdef RF_BYPASS_EN
        // Forwarding is suppressed under clr so outputs stay zero while it is held.
        if (!clr && wsel[rf.raddr_a]) begin
            rd_a = rf.wdata;
            if (!isel[rf.raddr_a])
                pd_a = 1'b0;
        end
        if (!clr && wsel[rf.raddr_b]) begin
            rd_b = rf.wdata;
            if (!isel[rf.raddr_b])
                pd_b = 1'b0;
        end
`endif
    end

    assign rf.rdata_a  = rd_a;
    assign rf.rdata_b  = rd_b;
    assign rf.pend_a   = pd_a;
    assign rf.pend_b   = pd_b;
    assign rf.pend_vec = pend;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed scenarios plus randomized traffic against an array-based model.
module tb_regfile_param;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    regfile_param_if #(.WIDTH(32), .DEPTH(32)) rf ();
    regfile_param_if #(.WIDTH(8),  .DEPTH(4))  sf ();

    regfile_param #(.WIDTH(32), .DEPTH(32)) u_dut (
        .clk (clk),
        .clr (clr),
        .rf  (rf)
    );

    regfile_param #(.WIDTH(8), .DEPTH(4)) u_small (
        .clk (clk),
        .clr (clr),
        .rf  (sf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        if (clr || a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (rf.we && int'(rf.waddr) == a) return rf.wdata;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_pd(input int a);
        if (clr || a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (rf.we && int'(rf.waddr) == a && !(rf.iss && int'(rf.iss_addr) == a)) return 1'b0;
`endif
        return m_pend[a];
    endfunction

    function automatic logic [31:0] exp_pv();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Called just after a rising edge: drive, check before the next edge, then advance the model.
    task automatic cyc(input bit w, input int wa, input logic [31:0] wd,
                       input int ra, input int rb, input bit is, input int ia);
        rf.we       = w;
        rf.waddr    = 5'(wa);
        rf.wdata    = wd;
        rf.raddr_a  = 5'(ra);
        rf.raddr_b  = 5'(rb);
        rf.iss      = is;
        rf.iss_addr = 5'(ia);
        @(negedge clk);
        #1;
        check_eq("rdata_a", rf.rdata_a, exp_rd(ra));
        check_eq("rdata_b", rf.rdata_b, exp_rd(rb));
        check_eq("pend_a", rf.pend_a, exp_pd(ra));
        check_eq("pend_b", rf.pend_b, exp_pd(rb));
        check_eq("pend_vec", rf.pend_vec, exp_pv());
        @(posedge clk);
        if (!clr) begin
            if (w && wa != 0) begin
                m_reg[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (is && ia != 0) m_pend[ia] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic quiet(input int ra, input int rb);
        rf.we = 1'b0; rf.iss = 1'b0;
        rf.raddr_a = 5'(ra); rf.raddr_b = 5'(rb);
        #1;
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        model_clear();
        clr = 1'b1;
        rf.we = 1'b1; rf.waddr = 5'd4; rf.wdata = 32'h1234_5678;
        rf.raddr_a = 5'd4; rf.raddr_b = 5'd0; rf.iss = 1'b1; rf.iss_addr = 5'd4;
        sf.we = 1'b0; sf.waddr = '0; sf.wdata = '0; sf.raddr_a = '0; sf.raddr_b = '0;
        sf.iss = 1'b0; sf.iss_addr = '0;
        #1;
        check_eq("rst_rdata_a", rf.rdata_a, 32'h0);
        check_eq("rst_pend_a", rf.pend_a, 1'b0);
        check_eq("rst_pend_vec", rf.pend_vec, 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        quiet(4, 0);
        check_eq("rst_write_discarded", rf.rdata_a, 32'h0);
        check_eq("rst_issue_discarded", rf.pend_vec, 32'h0);

        // Async clear in the middle of a cycle
        cyc(1, 5, 32'hDEAD_BEEF, 0, 0, 1, 6);
        quiet(5, 6);
        check_eq("pre_clr_r5", rf.rdata_a, 32'hDEAD_BEEF);
        @(negedge clk);
        clr = 1'b1;
        model_clear();
        #1;
        check_eq("clr_async_rdata", rf.rdata_a, 32'h0);
        check_eq("clr_async_pend", rf.pend_vec, 32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Write / read, r0 ignores writes
        cyc(1, 3, 32'h1234_5678, 0, 0, 0, 0);
        cyc(1, 31, 32'hCAFE_F00D, 3, 31, 0, 0);
        quiet(3, 31);
        check_eq("wr_r3", rf.rdata_a, 32'h1234_5678);
        check_eq("wr_r31", rf.rdata_b, 32'hCAFE_F00D);
        cyc(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        quiet(0, 0);
        check_eq("wr_r0", rf.rdata_a, 32'h0);

        // Scoreboard
        cyc(0, 0, 32'h0, 7, 0, 1, 7);
        quiet(7, 0);
        check_eq("iss_r7_vec", rf.pend_vec[7], 1'b1);
        check_eq("iss_r7_pend_a", rf.pend_a, 1'b1);
        cyc(1, 7, 32'h0000_00A5, 7, 0, 0, 0);
        quiet(7, 0);
        check_eq("wb_r7_pend", rf.pend_a, 1'b0);
        check_eq("wb_r7_data", rf.rdata_a, 32'h0000_00A5);
        cyc(1, 7, 32'h0000_005A, 7, 7, 1, 7);
        quiet(7, 7);
        check_eq("reiss_r7_pend", rf.pend_b, 1'b1);
        cyc(0, 0, 32'h0, 0, 0, 1, 0);
        quiet(0, 0);
        check_eq("iss_r0_ignored", rf.pend_vec[0], 1'b0);

        // Same-cycle write and read of r9
        cyc(1, 9, 32'h0000_1111, 0, 0, 0, 0);
        rf.we = 1'b1; rf.waddr = 5'd9; rf.wdata = 32'h0000_55AA;
        rf.raddr_a = 5'd9; rf.iss = 1'b0;
        #1;
`ifdef RF_BYPASS_EN
        check_eq("byp_same_cycle", rf.rdata_a, 32'h0000_55AA);
`else
        check_eq("byp_same_cycle", rf.rdata_a, 32'h0000_1111);
`endif
        cyc(1, 9, 32'h0000_55AA, 9, 0, 0, 0);
        quiet(9, 0);
        check_eq("byp_after_edge", rf.rdata_a, 32'h0000_55AA);

        // Both ports on the same register
        cyc(1, 12, 32'h0F0F_0F0F, 0, 0, 0, 0);
        quiet(12, 12);
        check_eq("dual_a", rf.rdata_a, 32'h0F0F_0F0F);
        check_eq("dual_b", rf.rdata_b, 32'h0F0F_0F0F);

        // Narrow instance: WIDTH=8, DEPTH=4
        sf.we = 1'b1; sf.waddr = 2'd3; sf.wdata = 8'hFF;
        idle();
        sf.we = 1'b0; sf.raddr_a = 2'd3;
        #1;
        check_eq("small_r3", sf.rdata_a, 8'hFF);
        sf.we = 1'b1; sf.waddr = 2'd0; sf.wdata = 8'hFF; sf.raddr_b = 2'd0;
        idle();
        sf.we = 1'b0;
        #1;
        check_eq("small_r0", sf.rdata_b, 8'h00);
        sf.iss = 1'b1; sf.iss_addr = 2'd3;
        idle();
        sf.iss = 1'b0;
        #1;
        check_eq("small_pend_vec", sf.pend_vec, 4'b1000);
        check_eq("small_pend_a", sf.pend_a, 1'b1);
        sf.iss = 1'b1; sf.iss_addr = 2'd0;
        idle();
        sf.iss = 1'b0;
        #1;
        check_eq("small_iss_r0", sf.pend_vec, 4'b1000);

        // Randomized traffic with occasional clr pulses
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b1;
                model_clear();
            end else if (clr) begin
                clr = 1'b0;
            end
            cyc(bit'($urandom_range(0, 1)), pick_addr(), $urandom,
                pick_addr(), pick_addr(), bit'($urandom_range(0, 1)), pick_addr());
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-port register file built from enable/clear flip-flop storage; generalises the single 32-bit enabled register to DEPTH registers of WIDTH bits.
- Sits between decode and execute in the processor datapath: one write port, two read ports, register 0 hardwired to zero.
- Adds a per-register pending (scoreboard) bit, so decode can detect read-after-write hazards on in-flight writes.

Parameters:
WIDTH, 32, data width of each register in bits
DEPTH, 32, number of registers (power of two, >= 2)
AW, $clog2(DEPTH), address width (derived; not to be overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  reset, asynchronous, active-high; clears all registers and pending bits
we  in  1  write enable
waddr  in  AW  write address
wdata  in  WIDTH  write data
raddr_a  in  AW  read port A address
raddr_b  in  AW  read port B address
rdata_a  out  WIDTH  read port A data
rdata_b  out  WIDTH  read port B data
iss  in  1  issue strobe: marks register iss_addr pending
iss_addr  in  AW  destination register of the issued instruction
pend_a  out  1  register at raddr_a has an outstanding write
pend_b  out  1  register at raddr_b has an outstanding write
pend_vec  out  DEPTH  all pending bits; bit 0 is always 0

Behaviour:
- Power-up/initial and clr=1: all registers 0 and all pending bits 0 immediately (asynchronous), without waiting for a clock edge. While clr is high, rdata_a/b=0, pend_a/b=0 and pend_vec=0.
- Write: on posedge clk with we=1, clr=0 and waddr!=0, reg[waddr]<=wdata. Writes to address 0 are ignored.
- Read: combinational. rdata_x = reg[raddr_x]; raddr_x=0 always returns 0.
- Pending bits, updated on posedge clk:
  - we=1, waddr!=0 clears pend[waddr].
  - iss=1, iss_addr!=0 sets pend[iss_addr].
  - Same address set and cleared in the same cycle: the set wins, so the bit stays 1 (a new instruction reissues the same destination).
  - iss_addr=0 is ignored.
  - A write to a non-pending register is legal and leaves its bit at 0.
- pend_x = pend[raddr_x], combinational. pend_x is 0 when raddr_x=0.
- Both read ports may address the same register; each returns identical data.
- clr asserted mid-operation aborts everything: it discards any write or issue in the cycle it overlaps. On clr deassertion, the first rising edge with clr=0 performs normal updates.
- No write latency beyond one edge: data written at edge N is visible on rdata from edge N (plus combinational delay).

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: write-through forwarding.
  - If we=1, waddr!=0 and raddr_x==waddr in the same cycle, rdata_x=wdata combinationally (before the edge).
  - pend_x is also forced to 0 for that port in that cycle, unless iss targets the same address in that cycle.
- Not defined: rdata_x reflects only stored contents, so same-cycle read of a register being written returns the old value. pend_x reflects only stored pending bits.

Test Plan:
- Reset: preload reg[5]=0xDEADBEEF, assert clr mid-cycle -> rdata_a (raddr_a=5) reads 0 before the next edge; pend_vec=0.
- Write/read: write 0x12345678 to r3 and 0xCAFEF00D to r31, read r3 on A and r31 on B -> exact values returned; write 0xFFFFFFFF to r0 -> rdata_a(raddr_a=0)=0.
- Scoreboard: iss r7 -> pend_vec[7]=1 next cycle. Then we r7=0xA5 -> pend bit cleared next cycle, rdata=0xA5. iss and we on r7 in the same cycle -> pend stays 1.
- Bypass, RF_BYPASS_EN defined: we r9=0x55AA with raddr_a=9 in the same cycle -> rdata_a=0x55AA before the edge.
- Bypass, RF_BYPASS_EN undefined: same stimulus -> rdata_a=old value until after the edge.
- Parametrisation: WIDTH=8, DEPTH=4 -> write 0xFF to r3 gives rdata=0xFF; address 0 stays zero; pend_vec is 4 bits wide.
- Dual-port same address: raddr_a=raddr_b=12 after writing 0x0F0F0F0F -> both ports return 0x0F0F0F0F.
